// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave in front of a word-organised SRAM array.
// Byte, halfword and word transfers use little-endian lane steering.
// OKAY responses complete with zero wait states.
// Optional macro AHB3LITE_SRAM_ERR_EN: illegal transfers get a two-cycle ERROR
// response. Illegal means misaligned, HSIZE > word, or out of range.
// Without the macro, illegal transfers are aligned down, oversize is treated as
// word, the address wraps, and HRESP stays 0.
// Only HDATA_SIZE = 32 is supported (4 byte lanes). MEM_DEPTH must be a power of two.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_OKAY | normal operation, HREADYOUT = 1, HRESP = 0
// ST_ERR1 | first ERROR cycle, HREADYOUT = 0, HRESP = 1
// ST_ERR2 | second ERROR cycle, HREADYOUT = 1, HRESP = 1

module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NLANE = HDATA_SIZE / 8;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  accept;
  logic                  illegal;
  logic                  valid_q;
  logic                  write_q;
  logic [HADDR_SIZE-1:0] addr_q;
  logic [2:0]            size_q;
  logic [IDX_W-1:0]      word_idx;
  logic [NLANE-1:0]      byte_mask;
  logic                  wr_en;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  // During ERR1 the bus HREADY is low anyway; the extra gate keeps a stray
  // HREADY from opening a transfer while the error is still being signalled.
  assign accept = HSEL & HTRANS[1] & HREADY & (state_q != ST_ERR1);

`ifdef AHB3LITE_SRAM_ERR_EN
  localparam logic [HADDR_SIZE-1:0] ADDR_LIMIT = HADDR_SIZE'(MEM_DEPTH * 4);

  // Classify the address phase as legal or illegal.
  always_comb begin
    illegal = 1'b0;
    if (HSIZE > 3'b010)                         illegal = 1'b1;
    if ((HSIZE == 3'b001) && HADDR[0])          illegal = 1'b1;
    if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) illegal = 1'b1;
    if (HADDR >= ADDR_LIMIT)                    illegal = 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  // Data-phase registers. An illegal transfer never opens a data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      valid_q <= accept & ~illegal;
      if (accept) begin
        write_q <= HWRITE;
        addr_q  <= HADDR;
        size_q  <= HSIZE;
      end
    end
  end

  assign word_idx = addr_q[IDX_W+1:2];
  assign wr_en    = valid_q & write_q & HREADY;

  // Lane mask. Misaligned accesses are aligned down, and oversize is treated as word.
  always_comb begin
    byte_mask = '0;
    case (size_q)
      3'b000: byte_mask[addr_q[1:0]] = 1'b1;
      3'b001: begin
        byte_mask[{addr_q[1], 1'b0}] = 1'b1;
        byte_mask[{addr_q[1], 1'b1}] = 1'b1;
      end
      default: byte_mask = '1;
    endcase
  end

  // Array write at the edge that closes the write data phase. The array has no reset.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int i = 0; i < NLANE; i++) begin
        if (byte_mask[i]) mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Read data comes straight from the array, so a write committed on the
  // opening edge is already visible without a forwarding path.
  assign HRDATA = (valid_q & ~write_q) ? mem[word_idx] : '0;

  // Response FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_OKAY;
    else          state_q <= state_d;
  end

  // Response FSM next state. ERR states are unreachable when illegal is tied low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OKAY: if (accept & illegal) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = (accept & illegal) ? ST_ERR1 : ST_OKAY;
      default: state_d = ST_OKAY;
    endcase
  end

  // Response FSM outputs.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  logic unused_sig;
  assign unused_sig = ^{HBURST, HPROT, HTRANS[0], addr_q[HADDR_SIZE-1:IDX_W+2]};

endmodule
